// File: rtl/arm_pkg.sv
// Shared ARM core constants: multiplier FSM encoding, datapath widths, R15 index.
package arm_pkg;

    localparam int unsigned XLEN           = 32;
    localparam int unsigned REG_IDX_W      = 4;
    localparam int unsigned BITS_PER_CYCLE = 8;

    localparam logic [REG_IDX_W-1:0] R15 = REG_IDX_W'(15);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_WB   = 2'd2
    } mul_state_t;

endpackage

// File: rtl/mul_unit_if.sv
// Operand/request and result/write-port bundle of the multiply unit.
interface mul_unit_if;
    import arm_pkg::*;

    logic                 start;
    logic                 accumulate;
    logic                 set_flags;
    logic [REG_IDX_W-1:0] Rd_in;
    logic [XLEN-1:0]      Rm_data;
    logic [XLEN-1:0]      Rs_data;
    logic [XLEN-1:0]      Rn_data;

    logic                 busy;
    logic                 done;
    logic                 latch_reg;
    logic [REG_IDX_W-1:0] Rd;
    logic [XLEN-1:0]      data_out;
    logic                 flag_n;
    logic                 flag_z;

    // Issuing side (decode/register read)
    modport master (
        output start, accumulate, set_flags, Rd_in, Rm_data, Rs_data, Rn_data,
        input  busy, done, latch_reg, Rd, data_out, flag_n, flag_z
    );

    // Multiply unit side
    modport slave (
        input  start, accumulate, set_flags, Rd_in, Rm_data, Rs_data, Rn_data,
        output busy, done, latch_reg, Rd, data_out, flag_n, flag_z
    );

endinterface

// File: rtl/mul_step.sv
// One multiply iteration: acc + mcand * digit, wrapped to 32 bits.
module mul_step
    import arm_pkg::*;
#(
    parameter int unsigned BITS_PER_CYCLE = arm_pkg::BITS_PER_CYCLE
) (
    input  logic [XLEN-1:0]           acc_i,
    input  logic [XLEN-1:0]           mcand_i,
    input  logic [BITS_PER_CYCLE-1:0] digit_i,
    output logic [XLEN-1:0]           sum_c
);

    // Partial product plus running sum; upper bits are dropped by the 32-bit context
    always_comb begin
        sum_c = acc_i + mcand_i * XLEN'(digit_i);
    end

endmodule

// File: rtl/mul_unit.sv
// Iterative MUL/MLA unit with early termination on an exhausted multiplier.
module mul_unit
    import arm_pkg::*;
#(
    parameter int unsigned BITS_PER_CYCLE = arm_pkg::BITS_PER_CYCLE
) (
    input  logic       clk,
    input  logic       rst_n,
    mul_unit_if.slave  bus
);

    mul_state_t           state_q, state_d;
    logic [XLEN-1:0]      acc_q, acc_d;
    logic [XLEN-1:0]      mcand_q, mcand_d;
    logic [XLEN-1:0]      mplier_q, mplier_d;
    logic [REG_IDX_W-1:0] rd_q, rd_d;
    logic                 sf_q, sf_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 latch_q, latch_d;
    logic [XLEN-1:0]      data_q, data_d;
    logic                 n_q, n_d;
    logic                 z_q, z_d;

    logic [XLEN-1:0]      step_sum;
    logic [XLEN-1:0]      mplier_next;
    logic                 last_iter;

    mul_step #(
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .acc_i   (acc_q),
        .mcand_i (mcand_q),
        .digit_i (mplier_q[BITS_PER_CYCLE-1:0]),
        .sum_c   (step_sum)
    );

    // Remaining multiplier after this iteration; zero means this is the last one
    always_comb begin
        mplier_next = mplier_q >> BITS_PER_CYCLE;
        last_iter   = (mplier_next == '0);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.start) state_d = ST_MUL;
            ST_MUL:  if (last_iter) state_d = ST_WB;
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and output next values; results are loaded on the last iteration so they show during WB
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        rd_d     = rd_q;
        sf_d     = sf_q;
        data_d   = data_q;
        n_d      = n_q;
        z_d      = z_q;
        done_d   = 1'b0;
        latch_d  = 1'b0;
        busy_d   = (state_d != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    acc_d    = bus.accumulate ? bus.Rn_data : '0;
                    mcand_d  = bus.Rm_data;
                    mplier_d = bus.Rs_data;
                    rd_d     = bus.Rd_in;
                    sf_d     = bus.set_flags;
                end
            end
            ST_MUL: begin
                acc_d    = step_sum;
                mcand_d  = mcand_q << BITS_PER_CYCLE;
                mplier_d = mplier_next;
                if (last_iter) begin
                    data_d  = step_sum;
                    done_d  = 1'b1;
                    latch_d = (rd_q != R15);
                    if (sf_q) begin
                        n_d = step_sum[XLEN-1];
                        z_d = (step_sum == '0);
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            rd_q     <= '0;
            sf_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            latch_q  <= 1'b0;
            data_q   <= '0;
            n_q      <= 1'b0;
            z_q      <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            rd_q     <= rd_d;
            sf_q     <= sf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            latch_q  <= latch_d;
            data_q   <= data_d;
            n_q      <= n_d;
            z_q      <= z_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.latch_reg = latch_q;
    assign bus.Rd        = rd_q;
    assign bus.data_out  = data_q;
    assign bus.flag_n    = n_q;
    assign bus.flag_z    = z_q;

endmodule

// File: tb/tb_mul_unit.sv
// Scoreboard bench for mul_unit: directed MUL/MLA vectors with hand-computed results.
module tb_mul_unit;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  rd;
        logic        latch;
        logic        n;
        logic        z;
    } exp_t;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    logic model_n = 1'b0;
    logic model_z = 1'b0;
    logic prev_done = 1'b0;
    exp_t sb[$];
    exp_t got;

    mul_unit_if bus ();

    mul_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every presented result against the scoreboard head
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.latch_reg && !bus.done)
                chk("latch_without_done", 32'(bus.latch_reg & ~bus.done), 32'd0);
            if (bus.done && prev_done)
                chk("done_back_to_back", 32'(prev_done & bus.done), 32'd0);
            if (bus.done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'(sb.size()), 32'd1);
                end else begin
                    got = sb.pop_front();
                    chk("data_out",  bus.data_out,        got.data);
                    chk("Rd",        32'(bus.Rd),         32'(got.rd));
                    chk("latch_reg", 32'(bus.latch_reg),  32'(got.latch));
                    chk("flag_n",    32'(bus.flag_n),     32'(got.n));
                    chk("flag_z",    32'(bus.flag_z),     32'(got.z));
                end
            end
            prev_done <= bus.done;
        end else begin
            prev_done <= 1'b0;
        end
    end

    task automatic drive(input logic acc, input logic s, input logic [3:0] rd,
                         input logic [31:0] rm, input logic [31:0] rs, input logic [31:0] rn);
        bus.start      = 1'b1;
        bus.accumulate = acc;
        bus.set_flags  = s;
        bus.Rd_in      = rd;
        bus.Rm_data    = rm;
        bus.Rs_data    = rs;
        bus.Rn_data    = rn;
    endtask

    task automatic push_exp(input logic s, input logic [3:0] rd, input logic [31:0] exp_data);
        exp_t e;
        if (s) begin
            model_n = exp_data[31];
            model_z = (exp_data == 32'd0);
        end
        e.data  = exp_data;
        e.rd    = rd;
        e.latch = (rd != 4'd15);
        e.n     = model_n;
        e.z     = model_z;
        sb.push_back(e);
    endtask

    // Count negedges with busy high after the start edge, bounded
    task automatic count_busy(output int cnt);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
            cnt++;
        end
    endtask

    task automatic do_op(input string name, input logic acc, input logic s, input logic [3:0] rd,
                         input logic [31:0] rm, input logic [31:0] rs, input logic [31:0] rn,
                         input logic [31:0] exp_data, input int exp_busy);
        int cnt;
        @(negedge clk);
        drive(acc, s, rd, rm, rs, rn);
        push_exp(s, rd, exp_data);
        @(posedge clk);
        #1 bus.start = 1'b0;
        count_busy(cnt);
        chk({name, "_busy_cycles"}, 32'(cnt), 32'(exp_busy));
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_busy"},  32'(bus.busy),      32'd0);
        chk({name, "_done"},  32'(bus.done),      32'd0);
        chk({name, "_latch"}, 32'(bus.latch_reg), 32'd0);
        chk({name, "_Rd"},    32'(bus.Rd),        32'd0);
        chk({name, "_data"},  bus.data_out,       32'd0);
        chk({name, "_n"},     32'(bus.flag_n),    32'd0);
        chk({name, "_z"},     32'(bus.flag_z),    32'd0);
    endtask

    initial begin
        int cnt;
        bus.start      = 1'b0;
        bus.accumulate = 1'b0;
        bus.set_flags  = 1'b0;
        bus.Rd_in      = 4'd0;
        bus.Rm_data    = 32'd0;
        bus.Rs_data    = 32'd0;
        bus.Rn_data    = 32'd0;
        rst_n          = 1'b0;
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        do_op("mul_3x5",   1'b0, 1'b0, 4'd2, 32'd3,          32'd5,          32'd0, 32'd15,         2);
        do_op("mla_wrap",  1'b1, 1'b1, 4'd6, 32'h0001_0000,  32'h0001_0000,  32'd7, 32'd7,          4);
        do_op("mul_ones",  1'b0, 1'b1, 4'd9, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0, 32'd1,          5);
        do_op("mul_neg",   1'b0, 1'b1, 4'd3, 32'h8000_0000,  32'd1,          32'd0, 32'h8000_0000,  2);
        do_op("mul_rs0",   1'b0, 1'b1, 4'd7, 32'h1234_5678,  32'd0,          32'd0, 32'd0,          2);
        do_op("flag_hold", 1'b0, 1'b0, 4'd4, 32'd2,          32'd3,          32'd0, 32'd6,          2);

        // start during MUL must be ignored
        @(negedge clk);
        drive(1'b0, 1'b0, 4'd3, 32'h0000_0100, 32'h0101_0101, 32'd0);
        push_exp(1'b0, 4'd3, 32'h0101_0100);
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        drive(1'b1, 1'b1, 4'd5, 32'd9, 32'd9, 32'd9);
        @(posedge clk);
        #1 bus.start = 1'b0;
        count_busy(cnt);
        chk("ignored_start_busy_cycles", 32'(cnt + 1), 32'd5);
        repeat (4) @(negedge clk);

        // reset in the middle of a long multiply
        drive(1'b0, 1'b1, 4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        model_n = 1'b0;
        model_z = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_op("mul_6x7",   1'b0, 1'b0, 4'd1, 32'd6,          32'd7,          32'd0, 32'd42,         2);
        do_op("rd15",      1'b0, 1'b1, 4'd15, 32'hFFFF_FFFF, 32'd1,          32'd0, 32'hFFFF_FFFF,  2);

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mul_unit.md
# mul_unit

Iterative multiply/multiply-accumulate execution unit for the ARMv4 core, implementing MUL and MLA. It consumes the operand values read from the register bank (Rm, Rs, Rn) and produces a 32-bit result, a destination register index and a one-cycle write strobe. These feed the register bank's write port (`data_in`, `Rd`, `latch_reg`) directly. Rs is processed 8 bits per cycle, with ARM7-style early termination when the remaining multiplier bits are zero.

## Interface
- `BITS_PER_CYCLE`, default 8: multiplier bits consumed per iteration; must divide 32.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  request; sampled only in IDLE.
- `accumulate`  in  1  1 = MLA (add Rn), 0 = MUL.
- `set_flags`  in  1  S bit; update N/Z on completion.
- `Rd_in`  in  4  destination register index.
- `Rm_data`  in  32  multiplicand.
- `Rs_data`  in  32  multiplier.
- `Rn_data`  in  32  accumulate addend.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle completion pulse.
- `latch_reg`  out  1  register-bank write strobe.
- `Rd`  out  4  captured destination index.
- `data_out`  out  32  result.
- `flag_n`  out  1  N flag.
- `flag_z`  out  1  Z flag.

## Operation
- States: IDLE, MUL, WB.
- **IDLE → MUL** on `start`. On that edge the block captures:
  - `acc = accumulate ? Rn_data : 0`
  - `mcand = Rm_data`
  - `mplier = Rs_data`
  - `Rd = Rd_in`
  - the `set_flags` bit
- **MUL, each cycle:**
  - `acc += mcand * mplier[7:0]`, truncated mod 2^32.
  - `mcand <<= 8`.
  - `mplier >>= 8`, zero fill.
  - Go to WB if the shifted `mplier` is 0, otherwise stay in MUL.
  - At least 1 iteration is always performed, even when Rs = 0.
  - At most 4 iterations are performed.
- Iteration count k = max(1, ceil(index of the highest set bit of Rs, plus 1, divided by 8)).
- **WB, one cycle:**
  - `data_out = acc`; `done = 1`.
  - `latch_reg = 1` unless `Rd == 15`. An R15 destination is unpredictable in ARMv4, so the write is suppressed, but `done` still pulses.
  - If the captured `set_flags` = 1: `flag_n = acc[31]`, `flag_z = (acc == 0)`. Otherwise the flags hold their previous values.
  - Next state is IDLE.
- Signedness: signed and unsigned operands give identical low 32 bits, so no sign handling is needed. Carry and overflow flags are not produced.
- `start` while `busy` is ignored; it is not queued.

## Timing
- Reset values: state IDLE; `busy`, `done`, `latch_reg`, `flag_n`, `flag_z` all 0; `Rd` 0; `data_out` 0; internal registers 0.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Let edge E0 be the edge that samples `start`:
  - `busy` rises after E0.
  - Iterations occur at edges E1..Ek.
  - `latch_reg`, `done` and `data_out` are valid in the cycle after Ek.
  - The register bank captures at edge Ek+1.
  - The block returns to IDLE at edge Ek+1, and `busy` falls.
- Total occupancy is k+1 cycles, between 2 and 5.
- The earliest next accepted `start` is at edge Ek+2.
- Operand inputs need to be stable only at E0; they are don't-care afterwards.
- Reset mid-operation: the block returns to IDLE immediately. No `latch_reg` or `done` is issued for the aborted operation, and the flags clear to 0.
- `latch_reg` and `done` are exactly one cycle wide and are never asserted back-to-back.

## Structure
- Shared package `arm_pkg`: state encoding constants (IDLE/MUL/WB), `BITS_PER_CYCLE`, and the R15 index constant.
- Sub-module `mul_step` (combinational): `acc + mcand * mplier[BITS_PER_CYCLE-1:0]` mod 2^32. This isolates the 32×8 partial-product adder for separate unit testing.
- Top level: FSM, operand/accumulator registers, output registers.

## Test plan
- MUL, Rm=3, Rs=5, Rd_in=2 → k=1; `latch_reg` high in the 2nd cycle after E0; `data_out`=15; `Rd`=2.
- MLA, Rm=0x00010000, Rs=0x00010000, Rn=7 → k=3; product wraps to 0, so `data_out`=7; with S=1, N=0, Z=0.
- MUL, Rm=0xFFFFFFFF, Rs=0xFFFFFFFF, S=1 → k=4; `data_out`=1; N=0, Z=0; `busy` high for 5 cycles.
- MUL, Rm=0x12345678, Rs=0, S=1 → k=1; `data_out`=0; Z=1; prior N is overwritten to 0.
- `start` pulsed during MUL is ignored. Then `rst_n` asserted mid-MUL → no `latch_reg`, all outputs 0. A following MUL 6×7 yields 42.
- MUL with Rd_in=15 → `done` pulses; `latch_reg` stays 0 throughout.
